// File: rtl/axi4_pkg.sv
// -----------------------------------------------------------------------------
// axi4_pkg
// Shared definitions for the AXI4-to-RAM-helper bridge: burst and response
// encodings, the read/write FSM state types, and address/strobe helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package axi4_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int unsigned BEAT_BYTES = 8;
   localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_READ = 2'd1,
      R_RESP = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   // Byte address -> 64-bit word index, wrapping modulo 2^64. The low
   // address bits are dropped by the shift: every beat is a full word.
   function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                               input logic [63:0] base);
      logic [63:0] off;
      off = addr - base;
      return off >> BEAT_SHIFT;
   endfunction

   // Expand each strobe bit into a full byte of the bit mask.
   function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
      logic [63:0] mask;
      for (int i = 0; i < 8; i++) begin
         mask[i*8 +: 8] = {8{strb[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/axi4_burst_idx_gen.sv
// -----------------------------------------------------------------------------
// axi4_burst_idx_gen
// Combinational next-word-index calculation for one AXI4 burst beat.
// Ports:
//   i_idx       current word index
//   i_len       AXI burst length (beats - 1)
//   i_burst     burst type (FIXED/INCR/WRAP; reserved behaves as INCR)
//   o_next_idx  word index of the following beat
// -----------------------------------------------------------------------------
module axi4_burst_idx_gen
   import axi4_pkg::*;
(
   input  logic [63:0] i_idx,
   input  logic [7:0]  i_len,
   input  logic [1:0]  i_burst,
   output logic [63:0] o_next_idx
);

   logic [63:0] w_inc;
   logic [63:0] w_wrap_mask;

   assign w_inc       = i_idx + 64'd1;
   // Legal WRAP lengths are 1/3/7/15, so len itself is the window mask.
   assign w_wrap_mask = {56'd0, i_len};

   always_comb begin
      o_next_idx = w_inc;
      case (i_burst)
         BURST_FIXED: o_next_idx = i_idx;
         BURST_INCR:  o_next_idx = w_inc;
         BURST_WRAP:  o_next_idx = (i_idx & ~w_wrap_mask) | (w_inc & w_wrap_mask);
         default:     o_next_idx = w_inc;
      endcase
   end

endmodule

// File: rtl/axi4_ram_bridge.sv
// -----------------------------------------------------------------------------
// axi4_ram_bridge
// AXI4 slave that turns FIXED/INCR/WRAP bursts on a 64-bit data bus into
// single-word accesses of the simulation RAM helper, one beat at a time.
// Read and write paths are independent FSMs.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   aw_* / w_* / b_*              AXI4 write address, data and response
//   ar_* / r_*                    AXI4 read address and data
//   ram_en, ram_rIdx, ram_rdata   helper read port (rdata is combinational)
//   ram_wen, ram_wIdx,
//   ram_wdata, ram_wmask          helper write port (commits at next posedge)
// -----------------------------------------------------------------------------
module axi4_ram_bridge
   import axi4_pkg::*;
#(
   parameter int unsigned ID_W      = 4,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            reset,
   // write address
   input  logic            aw_valid,
   output logic            aw_ready,
   input  logic [ID_W-1:0] aw_id,
   input  logic [63:0]     aw_addr,
   input  logic [7:0]      aw_len,
   input  logic [1:0]      aw_burst,
   // write data
   input  logic            w_valid,
   output logic            w_ready,
   input  logic [63:0]     w_data,
   input  logic [7:0]      w_strb,
   input  logic            w_last,
   // write response
   output logic            b_valid,
   input  logic            b_ready,
   output logic [ID_W-1:0] b_id,
   output logic [1:0]      b_resp,
   // read address
   input  logic            ar_valid,
   output logic            ar_ready,
   input  logic [ID_W-1:0] ar_id,
   input  logic [63:0]     ar_addr,
   input  logic [7:0]      ar_len,
   input  logic [1:0]      ar_burst,
   // read data
   output logic            r_valid,
   input  logic            r_ready,
   output logic [ID_W-1:0] r_id,
   output logic [63:0]     r_data,
   output logic [1:0]      r_resp,
   output logic            r_last,
   // RAM helper
   output logic            ram_en,
   output logic [63:0]     ram_rIdx,
   input  logic [63:0]     ram_rdata,
   output logic [63:0]     ram_wIdx,
   output logic [63:0]     ram_wdata,
   output logic [63:0]     ram_wmask,
   output logic            ram_wen
);

   // ---------------------------------------------------------------------------
   // Read path
   // ---------------------------------------------------------------------------
   rd_state_t       r_rd_state;
   rd_state_t       w_rd_state_nx;
   logic [ID_W-1:0] r_rd_id;
   logic [63:0]     r_rd_idx;
   logic [7:0]      r_rd_len;
   logic [1:0]      r_rd_burst;
   logic [7:0]      r_rd_cnt;
   logic [63:0]     r_rd_data;
   logic [63:0]     r_rd_idx_hold;
   logic [63:0]     w_rd_idx_nx;
   logic            w_rd_last;

   assign w_rd_last = (r_rd_cnt == r_rd_len);

   axi4_burst_idx_gen u_rd_idx_gen (
      .i_idx      (r_rd_idx),
      .i_len      (r_rd_len),
      .i_burst    (r_rd_burst),
      .o_next_idx (w_rd_idx_nx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_state <= R_IDLE;
      end else begin
         r_rd_state <= w_rd_state_nx;
      end
   end

   always_comb begin
      w_rd_state_nx = r_rd_state;
      ar_ready      = 1'b0;
      ram_en        = 1'b0;
      r_valid       = 1'b0;
      unique case (r_rd_state)
         R_IDLE: begin
            ar_ready = 1'b1;
            if (ar_valid) w_rd_state_nx = R_READ;
         end
         R_READ: begin
            ram_en        = 1'b1;
            w_rd_state_nx = R_RESP;
         end
         R_RESP: begin
            r_valid = 1'b1;
            if (r_ready) w_rd_state_nx = w_rd_last ? R_IDLE : R_READ;
         end
         default: w_rd_state_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_id       <= '0;
         r_rd_idx      <= '0;
         r_rd_len      <= '0;
         r_rd_burst    <= '0;
         r_rd_cnt      <= '0;
         r_rd_data     <= '0;
         r_rd_idx_hold <= '0;
      end else begin
         case (r_rd_state)
            R_IDLE: begin
               if (ar_valid) begin
                  r_rd_id    <= ar_id;
                  r_rd_idx   <= addr_to_idx(ar_addr, BASE_ADDR);
                  r_rd_len   <= ar_len;
                  r_rd_burst <= ar_burst;
                  r_rd_cnt   <= '0;
               end
            end
            R_READ: begin
               // Helper data is sampled here; any write committed at this
               // same edge is not yet visible, so the beat sees old data.
               r_rd_data     <= ram_rdata;
               r_rd_idx_hold <= r_rd_idx;
            end
            R_RESP: begin
               if (r_ready && !w_rd_last) begin
                  r_rd_idx <= w_rd_idx_nx;
                  r_rd_cnt <= r_rd_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ram_rIdx = (r_rd_state == R_READ) ? r_rd_idx : r_rd_idx_hold;
   assign r_id     = r_rd_id;
   assign r_data   = r_rd_data;
   assign r_resp   = RESP_OKAY;
   assign r_last   = (r_rd_state == R_RESP) && w_rd_last;

   // ---------------------------------------------------------------------------
   // Write path
   // ---------------------------------------------------------------------------
   wr_state_t       r_wr_state;
   wr_state_t       w_wr_state_nx;
   logic [ID_W-1:0] r_wr_id;
   logic [63:0]     r_wr_idx;
   logic [7:0]      r_wr_len;
   logic [1:0]      r_wr_burst;
   logic [7:0]      r_wr_cnt;
   logic [1:0]      r_wr_resp;
   logic [63:0]     r_wr_idx_hold;
   logic [63:0]     r_wr_data_hold;
   logic [63:0]     r_wr_mask_hold;
   logic [63:0]     w_wr_idx_nx;
   logic [63:0]     w_wr_mask;
   logic            w_wr_fire;
   logic            w_wr_cnt_done;
   logic            w_wr_end;

   assign w_wr_fire     = (r_wr_state == W_DATA) && w_valid;
   assign w_wr_cnt_done = (r_wr_cnt == r_wr_len);
   // Either the beat count or w_last terminates the burst; disagreement
   // between them is reported as SLVERR rather than hanging the channel.
   assign w_wr_end      = w_wr_cnt_done || w_last;
   assign w_wr_mask     = strb_to_mask(w_strb);

   axi4_burst_idx_gen u_wr_idx_gen (
      .i_idx      (r_wr_idx),
      .i_len      (r_wr_len),
      .i_burst    (r_wr_burst),
      .o_next_idx (w_wr_idx_nx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_state <= W_IDLE;
      end else begin
         r_wr_state <= w_wr_state_nx;
      end
   end

   always_comb begin
      w_wr_state_nx = r_wr_state;
      aw_ready      = 1'b0;
      w_ready       = 1'b0;
      b_valid       = 1'b0;
      unique case (r_wr_state)
         W_IDLE: begin
            aw_ready = 1'b1;
            if (aw_valid) w_wr_state_nx = W_DATA;
         end
         W_DATA: begin
            w_ready = 1'b1;
            if (w_valid && w_wr_end) w_wr_state_nx = W_RESP;
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (b_ready) w_wr_state_nx = W_IDLE;
         end
         default: w_wr_state_nx = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_id        <= '0;
         r_wr_idx       <= '0;
         r_wr_len       <= '0;
         r_wr_burst     <= '0;
         r_wr_cnt       <= '0;
         r_wr_resp      <= RESP_OKAY;
         r_wr_idx_hold  <= '0;
         r_wr_data_hold <= '0;
         r_wr_mask_hold <= '0;
      end else begin
         case (r_wr_state)
            W_IDLE: begin
               if (aw_valid) begin
                  r_wr_id    <= aw_id;
                  r_wr_idx   <= addr_to_idx(aw_addr, BASE_ADDR);
                  r_wr_len   <= aw_len;
                  r_wr_burst <= aw_burst;
                  r_wr_cnt   <= '0;
               end
            end
            W_DATA: begin
               if (w_valid) begin
                  r_wr_idx       <= w_wr_idx_nx;
                  r_wr_cnt       <= r_wr_cnt + 8'd1;
                  r_wr_idx_hold  <= r_wr_idx;
                  r_wr_data_hold <= w_data;
                  r_wr_mask_hold <= w_wr_mask;
                  if (w_wr_end) begin
                     r_wr_resp <= (w_last != w_wr_cnt_done) ? RESP_SLVERR : RESP_OKAY;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Write port is driven combinationally during an accepted beat and
   // otherwise holds the last beat's values.
   assign ram_wen   = w_wr_fire;
   assign ram_wIdx  = w_wr_fire ? r_wr_idx  : r_wr_idx_hold;
   assign ram_wdata = w_wr_fire ? w_data    : r_wr_data_hold;
   assign ram_wmask = w_wr_fire ? w_wr_mask : r_wr_mask_hold;
   assign b_id      = r_wr_id;
   assign b_resp    = r_wr_resp;

endmodule

// File: tb/tb_axi4_ram_bridge.sv
module tb_axi4_ram_bridge;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        aw_valid, aw_ready;
   logic [3:0]  aw_id;
   logic [63:0] aw_addr;
   logic [7:0]  aw_len;
   logic [1:0]  aw_burst;
   logic        w_valid, w_ready;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic        w_last;
   logic        b_valid, b_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;
   logic        ar_valid, ar_ready;
   logic [3:0]  ar_id;
   logic [63:0] ar_addr;
   logic [7:0]  ar_len;
   logic [1:0]  ar_burst;
   logic        r_valid, r_ready;
   logic [3:0]  r_id;
   logic [63:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;
   logic        ram_en, ram_wen;
   logic [63:0] ram_rIdx, ram_rdata, ram_wIdx, ram_wdata, ram_wmask;

   int checks = 0;
   int failures = 0;
   int wen_cnt = 0;
   int wen_start;

   logic [63:0] mem [0:63];

   always #5 clk = ~clk;

   axi4_ram_bridge #(
      .ID_W      (4),
      .BASE_ADDR (64'h8000_0000)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .aw_valid  (aw_valid),
      .aw_ready  (aw_ready),
      .aw_id     (aw_id),
      .aw_addr   (aw_addr),
      .aw_len    (aw_len),
      .aw_burst  (aw_burst),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .w_strb    (w_strb),
      .w_last    (w_last),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_id      (b_id),
      .b_resp    (b_resp),
      .ar_valid  (ar_valid),
      .ar_ready  (ar_ready),
      .ar_id     (ar_id),
      .ar_addr   (ar_addr),
      .ar_len    (ar_len),
      .ar_burst  (ar_burst),
      .r_valid   (r_valid),
      .r_ready   (r_ready),
      .r_id      (r_id),
      .r_data    (r_data),
      .r_resp    (r_resp),
      .r_last    (r_last),
      .ram_en    (ram_en),
      .ram_rIdx  (ram_rIdx),
      .ram_rdata (ram_rdata),
      .ram_wIdx  (ram_wIdx),
      .ram_wdata (ram_wdata),
      .ram_wmask (ram_wmask),
      .ram_wen   (ram_wen)
   );

   // RAM helper model: combinational read, masked write committed at posedge.
   // Initial contents: word i = 0xC0DE0000_0000000i.
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = {32'hC0DE_0000, 32'(i)};
   end
   assign ram_rdata = mem[ram_rIdx[5:0]];
   always @(posedge clk) begin
      if (ram_wen) begin
         mem[ram_wIdx[5:0]] <= (mem[ram_wIdx[5:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
         wen_cnt <= wen_cnt + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Full read burst with r_ready high; checks index, timing and payload per beat.
   task automatic rd_burst(input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id,
                           input logic [3:0][63:0] exp_idx,
                           input logic [3:0][63:0] exp_dat);
      ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_burst = burst; ar_id = id;
      r_ready = 1'b1;
      #1;
      chk("ar_ready", ar_ready, 1);
      tick();
      ar_valid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         chk("rd_ram_en", ram_en, 1);
         chk("rd_idx", ram_rIdx, exp_idx[b]);
         chk("rd_valid_early", r_valid, 0);
         tick();
         chk("rd_valid", r_valid, 1);
         chk("rd_id", r_id, id);
         chk("rd_data", r_data, exp_dat[b]);
         chk("rd_last", r_last, (b == int'(len)) ? 1 : 0);
         chk("rd_resp", r_resp, 0);
         chk("rd_en_resp", ram_en, 0);
         tick();
      end
      chk("rd_done_valid", r_valid, 0);
      chk("rd_done_ar_ready", ar_ready, 1);
   endtask

   task automatic aw_hs(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id);
      aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_burst = 2'b01; aw_id = id;
      #1;
      chk("aw_ready", aw_ready, 1);
      tick();
      aw_valid = 1'b0;
   endtask

   task automatic wr_beat(input logic [63:0] d, input logic [7:0] s, input logic l,
                          input logic [63:0] exp_idx, input logic [63:0] exp_mask);
      w_valid = 1'b1; w_data = d; w_strb = s; w_last = l;
      #1;
      chk("wr_ready", w_ready, 1);
      chk("wr_wen", ram_wen, 1);
      chk("wr_idx", ram_wIdx, exp_idx);
      chk("wr_data", ram_wdata, d);
      chk("wr_mask", ram_wmask, exp_mask);
      tick();
      w_valid = 1'b0;
      w_last = 1'b0;
   endtask

   task automatic wr_resp(input logic [3:0] id, input logic [1:0] resp);
      #1;
      chk("b_valid", b_valid, 1);
      chk("b_id", b_id, id);
      chk("b_resp", b_resp, resp);
      chk("b_wen_idle", ram_wen, 0);
      tick();
      chk("b_valid_held", b_valid, 1);
      chk("b_resp_held", b_resp, resp);
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      chk("b_done", b_valid, 0);
      chk("b_done_aw_ready", aw_ready, 1);
   endtask

   initial begin
      reset = 1'b1;
      aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_burst = 0;
      w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
      ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_burst = 0; r_ready = 0;
      tick();
      tick();

      // Reset state
      chk("rst_aw_ready", aw_ready, 1);
      chk("rst_ar_ready", ar_ready, 1);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_wen", ram_wen, 0);
      chk("rst_ridx", ram_rIdx, 0);
      chk("rst_widx", ram_wIdx, 0);
      chk("rst_wmask", ram_wmask, 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_r_last", r_last, 0);
      chk("rst_b_resp", b_resp, 0);
      reset = 1'b0;
      tick();

      // INCR read: idx 2..5
      rd_burst(64'h8000_0010, 8'd3, 2'b01, 4'd5,
               {64'd5, 64'd4, 64'd3, 64'd2},
               {64'hC0DE_0000_0000_0005, 64'hC0DE_0000_0000_0004,
                64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002});
      // WRAP read: 3,0,1,2
      rd_burst(64'h8000_0018, 8'd3, 2'b10, 4'd1,
               {64'd2, 64'd1, 64'd0, 64'd3},
               {64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001,
                64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0003});
      // FIXED read: 3,3,3
      rd_burst(64'h8000_0018, 8'd2, 2'b00, 4'd2,
               {64'd0, 64'd3, 64'd3, 64'd3},
               {64'd0, 64'hC0DE_0000_0000_0003,
                64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0003});

      // INCR write, 2 beats, partial strobe on the first
      aw_hs(64'h8000_0000, 8'd1, 4'd9);
      #1;
      chk("wr_ready_idle_beat", w_ready, 1);
      chk("wr_wen_no_valid", ram_wen, 0);
      wr_beat(64'h1111_2222_3333_4444, 8'h0F, 1'b0, 64'd0, 64'h0000_0000_FFFF_FFFF);
      wr_beat(64'h5555_6666_7777_8888, 8'hFF, 1'b1, 64'd1, ONES);
      wr_resp(4'd9, 2'b00);
      rd_burst(64'h8000_0000, 8'd1, 2'b01, 4'd3,
               {64'd0, 64'd0, 64'd1, 64'd0},
               {64'd0, 64'd0, 64'h5555_6666_7777_8888, 64'hC0DE_0000_3333_4444});

      // Protocol error: len 3 but w_last on beat 2
      wen_start = wen_cnt;
      aw_hs(64'h8000_0100, 8'd3, 4'd3);
      wr_beat(64'hAAAA_0000_0000_0020, 8'hFF, 1'b0, 64'd32, ONES);
      wr_beat(64'hAAAA_0000_0000_0021, 8'hFF, 1'b1, 64'd33, ONES);
      #1;
      chk("perr_wen_pulses", 64'(wen_cnt - wen_start), 2);
      wr_resp(4'd3, 2'b10);
      chk("perr_wen_after", 64'(wen_cnt - wen_start), 2);

      // Backpressure plus concurrent same-index write in the read's R_READ cycle
      aw_valid = 1'b1; aw_addr = 64'h8000_0140; aw_len = 0; aw_burst = 2'b01; aw_id = 4'd1;
      ar_valid = 1'b1; ar_addr = 64'h8000_0140; ar_len = 0; ar_burst = 2'b01; ar_id = 4'd6;
      r_ready = 1'b0; b_ready = 1'b0;
      tick();
      aw_valid = 1'b0; ar_valid = 1'b0;
      w_valid = 1'b1; w_data = 64'hDEAD_BEEF_0000_0040; w_strb = 8'hFF; w_last = 1'b1;
      #1;
      chk("conc_ram_en", ram_en, 1);
      chk("conc_ridx", ram_rIdx, 40);
      chk("conc_wen", ram_wen, 1);
      chk("conc_widx", ram_wIdx, 40);
      tick();
      w_valid = 1'b0; w_last = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("bp_r_valid", r_valid, 1);
         chk("bp_r_data_old", r_data, 64'hC0DE_0000_0000_0028);
         chk("bp_ram_en", ram_en, 0);
         chk("bp_r_last", r_last, 1);
         tick();
      end
      chk("conc_b_valid", b_valid, 1);
      chk("conc_b_resp", b_resp, 0);
      r_ready = 1'b1; b_ready = 1'b1;
      tick();
      r_ready = 1'b0; b_ready = 1'b0;
      chk("conc_r_done", r_valid, 0);
      chk("conc_b_done", b_valid, 0);
      rd_burst(64'h8000_0140, 8'd0, 2'b01, 4'd6,
               {64'd0, 64'd0, 64'd0, 64'd40},
               {64'd0, 64'd0, 64'd0, 64'hDEAD_BEEF_0000_0040});

      // Reset in the middle of a 4-beat read and a 4-beat write
      ar_valid = 1'b1; ar_addr = 64'h8000_0040; ar_len = 3; ar_burst = 2'b01; ar_id = 4'd7;
      aw_valid = 1'b1; aw_addr = 64'h8000_0180; aw_len = 3; aw_burst = 2'b01; aw_id = 4'd4;
      r_ready = 1'b1; b_ready = 1'b1;
      tick();
      ar_valid = 1'b0; aw_valid = 1'b0;
      w_valid = 1'b1; w_data = 64'hBBBB_0000_0000_0030; w_strb = 8'hFF; w_last = 1'b0;
      tick();
      w_data = 64'hBBBB_0000_0000_0031;
      #1;
      chk("mid_r_valid", r_valid, 1);
      chk("mid_wen", ram_wen, 1);
      reset = 1'b1;
      #1;
      chk("arst_r_valid", r_valid, 0);
      chk("arst_b_valid", b_valid, 0);
      chk("arst_wen", ram_wen, 0);
      chk("arst_ram_en", ram_en, 0);
      chk("arst_w_ready", w_ready, 0);
      chk("arst_ar_ready", ar_ready, 1);
      chk("arst_aw_ready", aw_ready, 1);
      tick();
      w_valid = 1'b0;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("post_rst_r_valid", r_valid, 0);
         chk("post_rst_b_valid", b_valid, 0);
         tick();
      end
      b_ready = 1'b0;
      aw_hs(64'h8000_01C0, 8'd0, 4'd8);
      wr_beat(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b1, 64'd56, ONES);
      wr_resp(4'd8, 2'b00);
      rd_burst(64'h8000_01C0, 8'd0, 2'b01, 4'd8,
               {64'd0, 64'd0, 64'd0, 64'd56},
               {64'd0, 64'd0, 64'd0, 64'h1234_5678_9ABC_DEF0});
      // Beat committed before reset persists; the aborted beat never landed.
      rd_burst(64'h8000_0180, 8'd1, 2'b01, 4'd4,
               {64'd0, 64'd0, 64'd49, 64'd48},
               {64'd0, 64'd0, 64'hC0DE_0000_0000_0031, 64'hBBBB_0000_0000_0030});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
